// File: rtl/tetris_ctrl_pkg.sv
// Shared types for the tetris controller: core state/command encoding,
// button index constants, controller FSM states and gravity helpers.
package enum_type;

    // Core states double as commands on ctrl; NONE means "no command".
    typedef enum logic [3:0] {
        NONE, INIT, GEN, WAIT, LEFT, RIGHT, ROTATE, ROTATE_REV,
        DOWN, DROP, HOLD, CLEAR, END
    } state_type;

    localparam int BTN_LEFT       = 0;
    localparam int BTN_RIGHT      = 1;
    localparam int BTN_ROTATE     = 2;
    localparam int BTN_ROTATE_REV = 3;
    localparam int BTN_DOWN       = 4;
    localparam int BTN_DROP       = 5;
    localparam int BTN_HOLD       = 6;
    localparam int NUM_BTN        = 7;

    typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_BUSY} ctrl_fsm_t;

    // BCD digit clamped to the legal level range 0..9.
    function automatic logic [3:0] clamp_level(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

    // max(base - lvl*step, floor_val) without wrapping below zero.
    function automatic logic [31:0] grav_period(input logic [3:0]  lvl,
                                                input logic [31:0] base,
                                                input logic [31:0] step,
                                                input logic [31:0] floor_val);
        logic [35:0] cut;
        cut = 36'(lvl) * 36'(step);
        if (cut >= {4'd0, base}) return floor_val;
        if ((base - cut[31:0]) < floor_val) return floor_val;
        return base - cut[31:0];
    endfunction

endpackage

// File: rtl/tetris_ctrl_if.sv
// Controller <-> core link. The controller (master) drives ctrl and level and
// watches state/score. ctrl is a one-cycle command: any non-NONE value is a
// request the core accepts only while in WAIT (or INIT/END for game start);
// there is no ready signal, acceptance is seen as the core leaving that state.
interface tetris_ctrl_if;
    import enum_type::*;

    state_type   state;
    logic [15:0] score;
    state_type   ctrl;
    logic [3:0]  level;
    ctrl_fsm_t   fsm_state;

    modport master (input state, input score, output ctrl, output level, output fsm_state);
    modport slave  (output state, output score, input ctrl, input level, input fsm_state);
endinterface

// File: rtl/tetris_ctrl_btn_edge.sv
// Per-button front end: 2-flop synchroniser, rising-edge pulse and, when
// TETRIS_AUTOREPEAT_EN is defined, a hold-to-repeat pulse (rpt).
module tetris_btn_edge #(
    parameter int unsigned DAS_DELAY  = 20_000_000,
    parameter int unsigned DAS_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise,
    output logic rpt
);
    logic sync0, sync1, prev;

    // Synchronise the raw button and keep the previous synced value for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            prev  <= sync1;
        end
    end

    assign rise = sync1 & ~prev;

`ifdef TETRIS_AUTOREPEAT_EN
    logic [31:0] hold_cnt;

    // Count held cycles since the edge; after the first repeat, reload so the next fires DAS_PERIOD later.
    always_ff @(posedge clk) begin
        if (reset || !sync1) begin
            hold_cnt <= '0;
        end else if (hold_cnt == DAS_DELAY) begin
            hold_cnt <= DAS_DELAY - DAS_PERIOD + 32'd1;
        end else begin
            hold_cnt <= hold_cnt + 32'd1;
        end
    end

    assign rpt = sync1 && (hold_cnt == DAS_DELAY);
`else
    assign rpt = 1'b0;
`endif

    // A repeat interval longer than the initial delay is a configuration error.
    if (DAS_PERIOD == 0 || DAS_PERIOD > DAS_DELAY) begin : g_bad_das
        $error("tetris_btn_edge: DAS_PERIOD must be 1..DAS_DELAY");
    end

endmodule

// File: rtl/tetris_ctrl.sv
// Command initiator for the tetris core: button pending flags, gravity timer,
// priority pick and the ctrl issue FSM. Optional hold-to-repeat for
// LEFT/RIGHT/DOWN is enabled by defining TETRIS_AUTOREPEAT_EN.
module tetris_ctrl
    import enum_type::*;
#(
    parameter int unsigned GRAVITY_CYCLES = 100_000_000,
    parameter int unsigned GRAVITY_STEP   = 8_000_000,
    parameter int unsigned GRAVITY_MIN    = 10_000_000,
    parameter int unsigned DAS_DELAY      = 20_000_000,
    parameter int unsigned DAS_PERIOD     = 5_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    tetris_ctrl_if.master      core
);
    localparam logic [NUM_BTN-1:0] RPT_MASK =
        NUM_BTN'((1 << BTN_LEFT) | (1 << BTN_RIGHT) | (1 << BTN_DOWN));

    logic [NUM_BTN-1:0] rise, rpt, btn_set, pending, clr;
    logic               grav_pend, grav_tick, clr_grav, in_menu;
    logic [31:0]        grav_cnt, period;
    logic [3:0]         level_q;
    state_type          ctrl_q, ctrl_next;
    ctrl_fsm_t          c_state, c_next;
    logic               unused_score_bits;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        tetris_btn_edge #(.DAS_DELAY(DAS_DELAY), .DAS_PERIOD(DAS_PERIOD)) u_edge (
            .clk   (clk),
            .reset (reset),
            .raw   (btn[i]),
            .rise  (rise[i]),
            .rpt   (rpt[i])
        );
    end

    assign btn_set           = rise | (rpt & RPT_MASK);
    assign in_menu           = (core.state == INIT) || (core.state == END);
    assign period            = grav_period(level_q, GRAVITY_CYCLES, GRAVITY_STEP, GRAVITY_MIN);
    // >= rather than == so a level-up that shortens the period below the count fires at once.
    assign grav_tick         = !in_menu && (core.state != GEN) && (grav_cnt >= period - 32'd1);
    assign unused_score_bits = ^{core.score[15:8], core.score[3:0]};

    // Level follows the score's tens digit, clamped to 9.
    always_ff @(posedge clk) begin
        if (reset) level_q <= '0;
        else       level_q <= clamp_level(core.score[7:4]);
    end

    // Gravity counter: frozen in INIT/END, cleared while the core generates a piece.
    always_ff @(posedge clk) begin
        if (reset || core.state == GEN) grav_cnt <= '0;
        else if (!in_menu)              grav_cnt <= grav_tick ? '0 : grav_cnt + 32'd1;
    end

    // Pending flags: new edges win over a same-cycle clear; INIT flushes everything.
    always_ff @(posedge clk) begin
        if (reset || core.state == INIT) begin
            pending   <= '0;
            grav_pend <= 1'b0;
        end else begin
            pending   <= (pending & ~clr) | btn_set;
            grav_pend <= (grav_pend & ~clr_grav) | grav_tick;
        end
    end

    // Issue FSM state and registered command.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_state <= C_IDLE;
            ctrl_q  <= NONE;
        end else begin
            c_state <= c_next;
            ctrl_q  <= ctrl_next;
        end
    end

    // Next state, command choice (fixed priority) and which pending flag it consumes.
    always_comb begin
        c_next    = c_state;
        ctrl_next = NONE;
        clr       = '0;
        clr_grav  = 1'b0;
        case (c_state)
            C_IDLE: begin
                if (core.state == WAIT && (|pending || grav_pend)) begin
                    c_next = C_ISSUE;
                    if (pending[BTN_HOLD]) begin
                        ctrl_next = HOLD;       clr[BTN_HOLD] = 1'b1;
                    end else if (pending[BTN_ROTATE]) begin
                        ctrl_next = ROTATE;     clr[BTN_ROTATE] = 1'b1;
                    end else if (pending[BTN_ROTATE_REV]) begin
                        ctrl_next = ROTATE_REV; clr[BTN_ROTATE_REV] = 1'b1;
                    end else if (pending[BTN_LEFT]) begin
                        ctrl_next = LEFT;       clr[BTN_LEFT] = 1'b1;
                    end else if (pending[BTN_RIGHT]) begin
                        ctrl_next = RIGHT;      clr[BTN_RIGHT] = 1'b1;
                    end else if (pending[BTN_DROP]) begin
                        ctrl_next = DROP;       clr[BTN_DROP] = 1'b1;
                    end else begin
                        ctrl_next = DOWN;       clr[BTN_DOWN] = 1'b1; clr_grav = 1'b1;
                    end
                end else if (in_menu && |btn_set) begin
                    c_next    = C_ISSUE;
                    ctrl_next = DOWN;
                end
            end
            C_ISSUE: c_next = C_BUSY;
            C_BUSY: begin
                if (core.state == WAIT || in_menu) c_next = C_IDLE;
            end
            default: c_next = C_IDLE;
        endcase
    end

    assign core.ctrl      = ctrl_q;
    assign core.level     = level_q;
    assign core.fsm_state = c_state;

endmodule

// File: tb/tb_tetris_ctrl.sv
// Self-checking bench for tetris_ctrl: reset, priority table, latency/one-cycle
// pulse, gravity periods per level, INIT/END start, reset mid-issue, hold
// behaviour and a randomized press/drain run against a priority-order model.
module tb_tetris_ctrl;
    import enum_type::*;

    logic               clk;
    logic               reset;
    logic [NUM_BTN-1:0] btn;
    tetris_ctrl_if      cif ();

    int        n_vec, n_miss;
    int        btn_left, busy_cnt, busy_len;
    bit        core_auto, saw_nonwait;
    state_type cmd_lat;
    state_type exp_q[$];
    state_type prio_cmd[NUM_BTN];
    int        prio_bit[NUM_BTN];

    typedef struct packed {
        logic [6:0]  mask;
        logic [15:0] score;
        state_type   first;
        logic [3:0]  lvl;
    } vec_t;
    vec_t vecs[10];

    tetris_ctrl #(
        .GRAVITY_CYCLES(100), .GRAVITY_STEP(8), .GRAVITY_MIN(10),
        .DAS_DELAY(20), .DAS_PERIOD(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .core  (cif.master)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: advance to negedge, release timed buttons, run the core model.
    task automatic step();
        @(negedge clk);
        if (btn_left > 0) begin
            btn_left--;
            if (btn_left == 0) btn = '0;
        end
        if (core_auto) begin
            if (cmd_lat != NONE) begin
                if (cif.state == INIT || cif.state == END) begin
                    cif.state = GEN;
                    busy_cnt  = 2;
                end else if (cif.state == WAIT) begin
                    cif.state = cmd_lat;
                    busy_cnt  = busy_len;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) cif.state = WAIT;
            end
        end
        cmd_lat = cif.ctrl;
        if (cif.state != WAIT) saw_nonwait = 1'b1;
    endtask

    task automatic press(input logic [NUM_BTN-1:0] mask, input int hold);
        btn      = mask;
        btn_left = hold;
    endtask

    task automatic wait_cmd(input int budget, output state_type cmd, output int cyc);
        cmd = NONE;
        cyc = 0;
        while (cyc < budget) begin
            step();
            cyc++;
            if (cif.ctrl != NONE) begin
                cmd = cif.ctrl;
                break;
            end
        end
    endtask

    task automatic do_reset();
        btn = '0; btn_left = 0; core_auto = 1'b0; busy_cnt = 0;
        reset = 1'b1;
        step();
        check("rst_ctrl", cif.ctrl, NONE);
        check("rst_level", cif.level, 0);
        reset = 1'b0;
        cmd_lat = NONE;
    endtask

    function automatic int model_period(input logic [15:0] score);
        int lvl;
        int p;
        lvl = (score[7:4] > 9) ? 9 : int'(score[7:4]);
        p   = 100 - lvl * 8;
        return (p < 10) ? 10 : p;
    endfunction

    task automatic measure_gravity(input logic [15:0] score);
        state_type c;
        int        cyc;
        wait_cmd(300, c, cyc);
        wait_cmd(300, c, cyc);
        wait_cmd(300, c, cyc);
        check("grav_cmd", c, DOWN);
        check("grav_period", cyc, model_period(score));
    endtask

    initial begin
        state_type cmd;
        int        cyc, n, exp_n;
        logic [6:0] mask;

        n_vec = 0; n_miss = 0;
        reset = 1'b1; btn = '0; btn_left = 0; core_auto = 1'b0;
        busy_len = 2; busy_cnt = 0; cmd_lat = NONE; saw_nonwait = 1'b0;
        cif.state = INIT; cif.score = '0;

        prio_cmd = '{HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, DROP, DOWN};
        prio_bit = '{BTN_HOLD, BTN_ROTATE, BTN_ROTATE_REV, BTN_LEFT, BTN_RIGHT, BTN_DROP, BTN_DOWN};

        vecs[0] = '{7'h01, 16'h0000, LEFT,       4'd0};
        vecs[1] = '{7'h03, 16'h0012, LEFT,       4'd1};
        vecs[2] = '{7'h12, 16'h0099, RIGHT,      4'd9};
        vecs[3] = '{7'h30, 16'h00A5, DROP,       4'd9};
        vecs[4] = '{7'h10, 16'h0040, DOWN,       4'd4};
        vecs[5] = '{7'h0C, 16'h0023, ROTATE,     4'd2};
        vecs[6] = '{7'h08, 16'h1234, ROTATE_REV, 4'd3};
        vecs[7] = '{7'h7F, 16'h00F0, HOLD,       4'd9};
        vecs[8] = '{7'h21, 16'h0070, LEFT,       4'd7};
        vecs[9] = '{7'h60, 16'h0085, HOLD,       4'd8};

        step(); step();
        check("reset_ctrl", cif.ctrl, NONE);
        check("reset_level", cif.level, 0);
        check("reset_fsm", cif.fsm_state, C_IDLE);
        reset = 1'b0;

        // Table: presses collected while the core generates, first command on WAIT.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            cif.score = vecs[v].score;
            cif.state = GEN;
            press(vecs[v].mask, 2);
            repeat (6) step();
            check("vec_level", cif.level, vecs[v].lvl);
            cif.state = WAIT;
            wait_cmd(10, cmd, cyc);
            check("vec_first", cmd, vecs[v].first);
        end

        // LEFT pulse is one cycle; next command only after the core leaves WAIT.
        do_reset();
        cif.score = '0; cif.state = WAIT; busy_len = 2; core_auto = 1'b1;
        press(7'h01, 2);
        wait_cmd(10, cmd, cyc);
        check("t1_left", cmd, LEFT);
        saw_nonwait = 1'b0;
        step();
        check("t1_width", cif.ctrl, NONE);
        press(7'h02, 2);
        wait_cmd(20, cmd, cyc);
        check("t1_right", cmd, RIGHT);
        check("t1_left_wait", saw_nonwait, 1);

        // Simultaneous HOLD and ROTATE: HOLD first.
        do_reset();
        cif.state = WAIT; core_auto = 1'b1;
        press(7'h44, 2);
        wait_cmd(10, cmd, cyc);
        check("t2_hold", cmd, HOLD);
        step();
        check("t2_width", cif.ctrl, NONE);
        wait_cmd(20, cmd, cyc);
        check("t2_rotate", cmd, ROTATE);

        // Gravity periods across levels, including a clamped digit.
        do_reset();
        cif.state = WAIT; core_auto = 1'b1; busy_len = 2;
        cif.score = 16'h0000; measure_gravity(cif.score);
        cif.score = 16'h0050; step(); step();
        check("grav_level5", cif.level, 5);
        measure_gravity(cif.score);
        cif.score = 16'h0090; measure_gravity(cif.score);
        cif.score = 16'h00C0; step(); step();
        check("grav_level_clamp", cif.level, 9);
        measure_gravity(cif.score);

        // Game start from INIT; stale DROP must not survive.
        do_reset();
        cif.score = '0; cif.state = INIT;
        press(7'h20, 2);
        wait_cmd(10, cmd, cyc);
        check("t4_init_down", cmd, DOWN);
        step();
        check("t4_init_width", cif.ctrl, NONE);
        repeat (3) step();
        cif.state = GEN; step(); step();
        cif.state = WAIT;
        wait_cmd(30, cmd, cyc);
        check("t4_no_stale", cmd, NONE);
        // Restart from END.
        cif.state = END;
        press(7'h08, 2);
        wait_cmd(10, cmd, cyc);
        check("t4_end_down", cmd, DOWN);
        step();
        check("t4_end_width", cif.ctrl, NONE);
        cif.state = INIT; repeat (4) step();
        cif.state = GEN; step(); step();
        cif.state = WAIT;
        wait_cmd(30, cmd, cyc);
        check("t4_end_flushed", cmd, NONE);

        // Reset while a command is being issued with everything pending.
        do_reset();
        cif.score = 16'h0030; cif.state = GEN;
        press(7'h7F, 2);
        repeat (5) step();
        cif.state = WAIT;
        wait_cmd(10, cmd, cyc);
        check("t5_hold", cmd, HOLD);
        check("t5_in_issue", cif.fsm_state, C_ISSUE);
        reset = 1'b1;
        step();
        check("t5_ctrl", cif.ctrl, NONE);
        check("t5_level", cif.level, 0);
        check("t5_fsm", cif.fsm_state, C_IDLE);
        reset = 1'b0;
        wait_cmd(50, cmd, cyc);
        check("t5_no_pending", cmd, NONE);
        check("t5_level_back", cif.level, 3);

        // Long hold of RIGHT.
        do_reset();
        cif.score = '0; cif.state = WAIT; core_auto = 1'b1; busy_len = 2;
        press(7'h02, 40);
        n = 0;
        for (int k = 0; k < 70; k++) begin
            step();
            if (cif.ctrl != NONE) begin
                n++;
                check("t6_cmd", cif.ctrl, RIGHT);
            end
        end
`ifdef TETRIS_AUTOREPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        check("t6_count", n, exp_n);

        // Randomized: random press set during GEN, drained in priority order.
        do_reset();
        cif.score = '0;
        for (int r = 0; r < 30; r++) begin
            core_auto = 1'b0;
            cif.state = GEN;
            mask = 7'($urandom_range(1, 127));
            for (int i = 0; i < NUM_BTN; i++) begin
                if (mask[i]) begin
                    press(7'(1 << i), $urandom_range(1, 2));
                    repeat ($urandom_range(3, 5)) step();
                end
            end
            repeat (4) step();
            for (int p = 0; p < NUM_BTN; p++)
                if (mask[prio_bit[p]]) exp_q.push_back(prio_cmd[p]);
            cmd_lat = NONE; busy_cnt = 0;
            core_auto = 1'b1;
            cif.state = WAIT;
            while (exp_q.size() > 0) begin
                busy_len = $urandom_range(1, 4);
                wait_cmd(40, cmd, cyc);
                check("rand_cmd", cmd, exp_q.pop_front());
                if (cmd == NONE) begin
                    exp_q.delete();
                    break;
                end
                step();
                check("rand_width", cif.ctrl, NONE);
            end
            wait_cmd(8, cmd, cyc);
            check("rand_drained", cmd, NONE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
